edge_detect_multi: RTL
======================

Name: edge_detect_multi

Overview:
Multi-channel, parametrised edge detector for asynchronous front-panel and board-level inputs such as keys, DIP switches and converter ready lines. Each channel provides:
- an input synchroniser
- a debounce filter
- a per-channel runtime edge-mode selection
- a stretched output pulse
- sticky event and overrun flags, clearable by the consumer

It sits between raw pins and control FSMs (ADC/DAC sequencers, LCD/OLED menu logic).

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2)
DEBOUNCE, 4, consecutive stable cycles required before a level change is accepted (0 = no filtering, same as 1)
PULSE_WIDTH, 1, dout high time in clk cycles per accepted edge (>=1)
RETRIG, 1, 1 = a new edge during an active pulse reloads the width; 0 = the edge is ignored for dout and flags overrun

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
din  in  CHANNELS  raw asynchronous inputs
mode  in  2*CHANNELS  per-channel edge mode, bits [2c+1:2c] (0 rising, 1 falling, 2 both, 3 disabled)
evt_clr  in  CHANNELS  per-channel clear of evt_flag and overrun (synchronous, level)
dout  out  CHANNELS  stretched edge pulse
level  out  CHANNELS  debounced input level
evt_flag  out  CHANNELS  sticky "edge occurred" flag
overrun  out  CHANNELS  sticky "edge lost" flag (RETRIG=0 only; constant 0 otherwise)

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-low (rst_n). All registers clear to 0 on reset: synchroniser chain, debounce counter, level, pulse counter, dout, evt_flag, overrun.
- Synchroniser: a chain of SYNC_STAGES flip-flops; s = last stage. No logic between stages.
- Debounce, per channel (counter width clog2(DEBOUNCE+1)):
  - if s == level: cnt <= 0
  - else if cnt == max(DEBOUNCE,1)-1: level <= s, cnt <= 0, and an accepted transition is raised this edge
  - else: cnt <= cnt+1
  - Any glitch shorter than max(DEBOUNCE,1) cycles restarts the count and produces no transition.
- Qualification: an accepted transition is qualified if mode = 0 and the new level is 1, mode = 1 and the new level is 0, or mode = 2 (either direction). Mode 3 never qualifies. mode is sampled at the same clock edge as the transition; mode changes at other times have no effect.
- Latency: din changes and is held stable, and is first sampled at clock edge k. level and dout rise at edge k + SYNC_STAGES + max(DEBOUNCE,1) - 1. With defaults this is edge k+5.
- Pulse, using a pulse counter pcnt:
  - on a qualified transition with pcnt == 0: pcnt <= PULSE_WIDTH
  - with pcnt != 0 on a qualified transition: RETRIG=1 reloads PULSE_WIDTH; RETRIG=0 leaves pcnt as is and sets overrun
  - otherwise pcnt decrements toward 0
  - dout is registered: dout = 1 exactly while pcnt != 0. One isolated edge gives exactly PULSE_WIDTH high cycles.
- Flags:
  - evt_flag sets on every qualified transition and holds until evt_clr.
  - If set and clear occur in the same cycle, set wins (flag stays 1).
  - overrun follows the same rules.
  - evt_clr affects neither dout nor level.
- Reset release with din held high: level=0, so after the latency a rising transition is accepted and reported if the mode qualifies. Consumers must mask this themselves.
- Reset asserted mid-pulse or mid-count: everything is cleared immediately; no partial pulse is produced afterward.
- Channels are fully independent; there is no cross-channel priority.

Decomposition:
- Package edge_detect_pkg:
  - mode encodings EDGE_RISE=2'd0, EDGE_FALL=2'd1, EDGE_BOTH=2'd2, EDGE_OFF=2'd3
  - a clog2 helper function
- One sub-module, edge_detect_chan: a single channel (sync, debounce, qualify, pulse, flags) carrying the same parameters minus CHANNELS. The top instantiates it CHANNELS times in a generate loop and slices mode.

Test Plan:
- Defaults, ch0 mode 0: din[0] 0->1 held, first sampled at edge k -> level[0] and dout[0] rise at edge k+5; dout[0] high exactly 1 cycle; evt_flag[0]=1; other channels stay 0.
- DEBOUNCE=4: din[1] glitch of 3 cycles high -> no level change, no dout, evt_flag stays 0. Then 4 stable cycles -> transition accepted.
- mode = 1 / 2 / 3 on ch2, with a 0->1->0 input: falling edge only gives 1 pulse; both gives 2 pulses and evt_flag set; disabled gives no pulse but level still follows.
- PULSE_WIDTH=8, RETRIG=0, edges 5 cycles apart in mode 2: dout high 8 cycles for the first edge only and overrun=1. With RETRIG=1 the same stimulus gives dout high 13 cycles total and overrun stays 0.
- evt_clr[0] asserted in the same cycle as a qualified edge -> evt_flag[0] remains 1. evt_clr alone next cycle -> evt_flag[0]=0.
- rst_n pulled low during an active 8-cycle pulse -> dout, flags and level go 0 asynchronously. After release with din low: no output.

Source files
------------

// File: rtl/edge_detect_pkg.sv
// Shared definitions for the multi-channel edge detector: edge-mode encodings
// and a constant-width helper.
package edge_detect_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2,
        EDGE_OFF  = 2'd3
    } edge_mode_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        longint unsigned x;
        r = 0;
        x = 1;
        while (x < longint'(v)) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One edge-detector channel: synchroniser, debounce filter, edge qualification,
// stretched output pulse and sticky event/overrun flags.
module edge_detect_chan
    import edge_detect_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned PULSE_WIDTH = 1,
    parameter int unsigned RETRIG      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  edge_mode_e mode,
    input  logic       evt_clr,
    output logic       dout,
    output logic       level,
    output logic       evt_flag,
    output logic       overrun
);

    localparam int unsigned DB_MAX = (DEBOUNCE < 1) ? 1 : DEBOUNCE;
    localparam int unsigned CNT_W  = (clog2(DEBOUNCE + 1) < 1) ? 1 : clog2(DEBOUNCE + 1);
    localparam int unsigned PCNT_W = (clog2(PULSE_WIDTH + 1) < 1) ? 1 : clog2(PULSE_WIDTH + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [PCNT_W-1:0]      r_pcnt;
    logic [PCNT_W-1:0]      w_pcnt_nxt;
    logic                   r_level;
    logic                   r_dout;
    logic                   r_evt;
    logic                   r_ovr;
    logic                   w_s;
    logic                   w_accept;
    logic                   w_qual;
    logic                   w_busy;
    logic                   w_lost;

    always_comb begin
        w_s      = r_sync[SYNC_STAGES-1];
        w_accept = (w_s != r_level) && (r_cnt == CNT_W'(DB_MAX - 1));
        w_qual   = 1'b0;
        if (w_accept) begin
            case (mode)
                EDGE_RISE: w_qual = w_s;
                EDGE_FALL: w_qual = ~w_s;
                EDGE_BOTH: w_qual = 1'b1;
                default:   w_qual = 1'b0;
            endcase
        end
        // A lost edge (no retrigger) lets the running pulse keep counting down.
        w_busy = (r_pcnt != '0);
        w_lost = w_qual && w_busy && (RETRIG == 0);
        if (w_qual && !w_lost) begin
            w_pcnt_nxt = PCNT_W'(PULSE_WIDTH);
        end else if (w_busy) begin
            w_pcnt_nxt = r_pcnt - PCNT_W'(1);
        end else begin
            w_pcnt_nxt = r_pcnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pcnt  <= '0;
            r_dout  <= 1'b0;
            r_evt   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};

            if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= w_s;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            r_pcnt <= w_pcnt_nxt;
            r_dout <= (w_pcnt_nxt != '0);

            // Set takes priority over a simultaneous clear.
            if (w_qual)       r_evt <= 1'b1;
            else if (evt_clr) r_evt <= 1'b0;

            if (w_lost)       r_ovr <= 1'b1;
            else if (evt_clr) r_ovr <= 1'b0;
        end
    end

    assign dout     = r_dout;
    assign level    = r_level;
    assign evt_flag = r_evt;
    assign overrun  = r_ovr;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: CHANNELS independent copies of edge_detect_chan,
// each taking its own 2-bit slice of the mode vector.
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned PULSE_WIDTH = 1,
    parameter int unsigned RETRIG      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   din,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   evt_clr,
    output logic [CHANNELS-1:0]   dout,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   evt_flag,
    output logic [CHANNELS-1:0]   overrun
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        edge_detect_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE   (DEBOUNCE),
            .PULSE_WIDTH(PULSE_WIDTH),
            .RETRIG     (RETRIG)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .din     (din[c]),
            .mode    (edge_mode_e'(mode[2*c +: 2])),
            .evt_clr (evt_clr[c]),
            .dout    (dout[c]),
            .level   (level[c]),
            .evt_flag(evt_flag[c]),
            .overrun (overrun[c])
        );
    end

endmodule
